pixel_result_queue: RTL and testbench
=====================================

Name: pixel_result_queue

Overview:
- Buffers finished pixel results (pixel x, pixel y, iteration count) from one mandelbrot engine.
- Results are pushed in completion order and popped by the downstream colour/pixel-stream stage over a valid/ready handshake.
- Drives the engine's full_queue stall input so the engine holds off instead of losing results.
- Sits directly downstream of the engine, one instance per engine.

Parameters:
DEPTH, 16, number of result entries; power of two, >= 4
PIXEL_DATA_WIDTH, 10, width of pixel x/y coordinates
ITERATIONS_WIDTH, 6, width of iteration count
FULL_MARGIN, 2, free-entry headroom at which full_queue asserts; covers engine stall latency; 1 <= FULL_MARGIN < DEPTH

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of queue contents and overflow flag
in_valid  input  1  engine result valid this cycle (push request)
in_xpixel  input  PIXEL_DATA_WIDTH  pixel x of finished result
in_ypixel  input  PIXEL_DATA_WIDTH  pixel y of finished result
in_iterations  input  ITERATIONS_WIDTH  iteration count of finished result
full_queue  output  1  stall request to engine
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry this cycle
out_xpixel  output  PIXEL_DATA_WIDTH  head entry pixel x
out_ypixel  output  PIXEL_DATA_WIDTH  head entry pixel y
out_iterations  output  ITERATIONS_WIDTH  head entry iteration count
count  output  $clog2(DEPTH)+1  current number of stored entries
overflow  output  1  sticky; a push was dropped

Behaviour:
- Reset (reset=0, asynchronous):
  - Read pointer, write pointer and count clear to 0; overflow clears to 0.
  - out_valid=0, full_queue=0.
  - out_* payload is don't-care while out_valid=0, but must not be X after the first push.
- Storage:
  - DEPTH x (2*PIXEL_DATA_WIDTH+ITERATIONS_WIDTH) register/RAM array, entry packed {x, y, iterations}.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: occurs when in_valid=1 and (count<DEPTH or a pop occurs the same cycle). The entry is written at the write pointer and the pointer increments.
- Pop: occurs when out_valid=1 and out_ready=1. The read pointer increments.
- Count update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- First-word-fall-through output:
  - out_valid = (count != 0).
  - out_* shows the entry at the read pointer.
  - A push into an empty queue at edge N appears with out_valid=1 in the cycle after edge N (1-cycle latency).
  - No zero-cycle bypass.
- Payload stability: out_* must not change while out_valid=1 and out_ready=0.
- full_queue:
  - Combinational: full_queue = (count >= DEPTH-FULL_MARGIN).
  - Deasserts as soon as count drops below the threshold.
- Drop at full: in_valid=1 with count==DEPTH and no simultaneous pop:
  - The entry is dropped and the queue is unchanged.
  - overflow sets to 1 and holds until flush or reset.
- Simultaneous events:
  - Push and pop with count==0: only the push takes effect, since out_valid=0 means no pop.
  - Push and pop with count==DEPTH: both take effect; count stays DEPTH and there is no overflow.
  - flush has priority over push and pop in the same cycle. Pointers and count go to 0 and overflow clears; an in_valid that cycle is discarded.
- out_ready while out_valid=0: ignored.
- Reset mid-operation: all stored entries are lost; outputs return to reset values immediately (asynchronous).
- No combinational path from out_ready to full_queue other than through registered count.

Test Plan:
- Reset then push 3 results (x=5,y=7,it=12), (x=6,y=7,it=63), (x=7,y=7,it=0) with out_ready=0 -> count=3, out_valid=1, head shows (5,7,12) unchanged for 10 cycles; then out_ready=1 -> pops in exactly that order, count reaches 0, out_valid=0.
- DEPTH=16, FULL_MARGIN=2: push 14 entries with no pops -> full_queue=0 at count 13, 1 at count 14; one pop -> full_queue=0 the cycle after.
- Push 17 entries back-to-back with out_ready=0 -> count saturates at 16, overflow=1 after the 17th, entries 0..15 pop intact, 17th absent; overflow remains 1 until flush.
- Full queue (count=16), in_valid=1 and out_ready=1 together for 40 cycles with incrementing x -> count stays 16, overflow stays 0, popped sequence is continuous across pointer wrap.
- flush=1 coincident with in_valid=1 and out_ready=1 at count=5 -> next cycle count=0, out_valid=0, overflow=0, flushed-cycle entry never appears.
- Assert reset=0 asynchronously mid-stream at count=9 (between clock edges) -> count=0, out_valid=0, full_queue=0 immediately; after release, a push of (x=1,y=2,it=3) pops as the only entry.

Source files
------------

// File: rtl/pixel_result_queue.sv
// Result FIFO between one mandelbrot engine and the colour/pixel-stream stage.
// First-word-fall-through output, early stall (full_queue) and sticky overflow on dropped pushes.
module pixel_result_queue #(
  parameter int DEPTH            = 16,
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int ITERATIONS_WIDTH = 6,
  parameter int FULL_MARGIN      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [PIXEL_DATA_WIDTH-1:0]   in_xpixel,
  input  logic [PIXEL_DATA_WIDTH-1:0]   in_ypixel,
  input  logic [ITERATIONS_WIDTH-1:0]   in_iterations,
  output logic                          full_queue,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PIXEL_DATA_WIDTH-1:0]   out_xpixel,
  output logic [PIXEL_DATA_WIDTH-1:0]   out_ypixel,
  output logic [ITERATIONS_WIDTH-1:0]   out_iterations,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2*PIXEL_DATA_WIDTH + ITERATIONS_WIDTH;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - FULL_MARGIN);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          push;
  logic          pop;
  logic          drop;

  // A full queue can still accept a push when the head leaves in the same cycle.
  always_comb begin
    pop  = (count_q != '0) && out_ready;
    push = in_valid && ((count_q < DEPTH_C) || pop);
    drop = in_valid && !push;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count_q <= count_q + CW'(1);
      else if (pop && !push)
        count_q <= count_q - CW'(1);
      if (drop)
        overflow_q <= 1'b1;
    end
  end

  // Storage has no reset; the head is only meaningful once an entry has been written.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= {in_xpixel, in_ypixel, in_iterations};
  end

  always_comb begin
    {out_xpixel, out_ypixel, out_iterations} = mem[rd_ptr];
    out_valid  = (count_q != '0);
    full_queue = (count_q >= THRESH_C);
    count      = count_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_pixel_result_queue.sv
// Directed bench for pixel_result_queue: a queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_pixel_result_queue;

  localparam int DEPTH = 16;
  localparam int PW    = 10;
  localparam int IW    = 6;
  localparam int FM    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_xpixel = '0;
  logic [PW-1:0] in_ypixel = '0;
  logic [IW-1:0] in_iterations = '0;
  logic          full_queue;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_xpixel;
  logic [PW-1:0] out_ypixel;
  logic [IW-1:0] out_iterations;
  logic [CW-1:0] count;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  pixel_result_queue #(
    .DEPTH(DEPTH), .PIXEL_DATA_WIDTH(PW), .ITERATIONS_WIDTH(IW), .FULL_MARGIN(FM)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_xpixel(in_xpixel), .in_ypixel(in_ypixel),
    .in_iterations(in_iterations), .full_queue(full_queue),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_xpixel(out_xpixel), .out_ypixel(out_ypixel),
    .out_iterations(out_iterations), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of {x, y, it} entries and an overflow flag.
  typedef struct packed {
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    logic [IW-1:0] it;
  } entry_t;

  entry_t model_q[$];
  bit     model_ovf = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else if (flush) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      bit do_pop;
      bit do_push;
      entry_t e;
      do_pop  = (model_q.size() > 0) && out_ready;
      do_push = in_valid && ((model_q.size() < DEPTH) || do_pop);
      e.x = in_xpixel;
      e.y = in_ypixel;
      e.it = in_iterations;
      if (do_pop)
        void'(model_q.pop_front());
      if (do_push)
        model_q.push_back(e);
      if (in_valid && !do_push)
        model_ovf = 1'b1;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check_output("model_count", int'(count), model_q.size());
      check_output("model_out_valid", int'(out_valid), int'(model_q.size() > 0));
      check_output("model_full_queue", int'(full_queue), int'(model_q.size() >= DEPTH - FM));
      check_output("model_overflow", int'(overflow), int'(model_ovf));
      if (model_q.size() > 0) begin
        check_output("model_head_x", int'(out_xpixel), int'(model_q[0].x));
        check_output("model_head_y", int'(out_ypixel), int'(model_q[0].y));
        check_output("model_head_it", int'(out_iterations), int'(model_q[0].it));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit v, input int x, input int y, input int it, input bit rdy);
    in_valid      = v;
    in_xpixel     = PW'(x);
    in_ypixel     = PW'(y);
    in_iterations = IW'(it);
    out_ready     = rdy;
    step();
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic check_head(input string name, input int x, input int y, input int it);
    check_output({name, "_x"}, int'(out_xpixel), x);
    check_output({name, "_y"}, int'(out_ypixel), y);
    check_output({name, "_it"}, int'(out_iterations), it);
  endtask

  initial begin
    $display("[TB] start");
    reset = 1'b0;
    repeat (2) step();
    check_output("reset_count", int'(count), 0);
    check_output("reset_out_valid", int'(out_valid), 0);
    check_output("reset_full_queue", int'(full_queue), 0);
    check_output("reset_overflow", int'(overflow), 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Three pushes, head held for 10 cycles, then drained in order.
    apply_stimulus(1, 5, 7, 12, 0);
    apply_stimulus(1, 6, 7, 63, 0);
    apply_stimulus(1, 7, 7, 0, 0);
    idle();
    check_output("t1_count", int'(count), 3);
    check_output("t1_out_valid", int'(out_valid), 1);
    check_head("t1_head", 5, 7, 12);
    repeat (10) step();
    check_head("t1_held", 5, 7, 12);
    out_ready = 1'b1;
    step();
    check_head("t1_pop2", 6, 7, 63);
    step();
    check_head("t1_pop3", 7, 7, 0);
    step();
    check_output("t1_empty_count", int'(count), 0);
    check_output("t1_empty_valid", int'(out_valid), 0);
    idle();

    // full_queue threshold at DEPTH-FULL_MARGIN.
    for (int i = 0; i < 13; i++) apply_stimulus(1, i, 0, 0, 0);
    idle();
    check_output("t2_full_at13", int'(full_queue), 0);
    apply_stimulus(1, 13, 0, 0, 0);
    idle();
    check_output("t2_full_at14", int'(full_queue), 1);
    apply_stimulus(0, 0, 0, 0, 1);
    idle();
    check_output("t2_count_after_pop", int'(count), 13);
    check_output("t2_full_after_pop", int'(full_queue), 0);
    do_flush();

    // Overflow: 17 back-to-back pushes, 17th dropped.
    for (int i = 0; i < 17; i++) apply_stimulus(1, i, i + 100, i, 0);
    idle();
    check_output("t3_count", int'(count), 16);
    check_output("t3_overflow", int'(overflow), 1);
    check_output("t3_full", int'(full_queue), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_head("t3_pop", i, i + 100, i);
      step();
    end
    idle();
    check_output("t3_drained_valid", int'(out_valid), 0);
    check_output("t3_overflow_sticky", int'(overflow), 1);
    do_flush();
    check_output("t3_overflow_flushed", int'(overflow), 0);

    // Full queue with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < 16; i++) apply_stimulus(1, i, i + 100, i, 0);
    for (int i = 0; i < 40; i++) begin
      check_output("t4_stream_x", int'(out_xpixel), i);
      apply_stimulus(1, 16 + i, 116 + i, 16 + i, 1);
    end
    idle();
    check_output("t4_count", int'(count), 16);
    check_output("t4_overflow", int'(overflow), 0);
    check_head("t4_head", 40, 140, 40 % 64);
    do_flush();

    // Flush beats a coincident push and pop.
    for (int i = 0; i < 5; i++) apply_stimulus(1, i, 1, 1, 0);
    flush = 1'b1;
    apply_stimulus(1, 99, 99, 9, 1);
    idle();
    check_output("t5_count", int'(count), 0);
    check_output("t5_out_valid", int'(out_valid), 0);
    check_output("t5_overflow", int'(overflow), 0);
    apply_stimulus(1, 42, 43, 44, 0);
    idle();
    check_output("t5_after_count", int'(count), 1);
    check_head("t5_after_head", 42, 43, 44);
    do_flush();

    // Asynchronous reset mid-stream between clock edges.
    for (int i = 0; i < 9; i++) apply_stimulus(1, i, 2, 3, 0);
    idle();
    check_output("t6_pre_count", int'(count), 9);
    #2;
    reset = 1'b0;
    #1;
    check_output("t6_async_count", int'(count), 0);
    check_output("t6_async_valid", int'(out_valid), 0);
    check_output("t6_async_full", int'(full_queue), 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    apply_stimulus(1, 1, 2, 3, 0);
    idle();
    check_output("t6_post_count", int'(count), 1);
    check_head("t6_post_head", 1, 2, 3);
    apply_stimulus(0, 0, 0, 0, 1);
    idle();
    check_output("t6_post_empty", int'(out_valid), 0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
